// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: step controls, load port and count/pulse outputs.
// The master drives the controls; the counter is the slave.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             DIR;
  logic             SAT;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             TC;
  logic             WRAP;
  logic             SAT_HIT;

  modport master (
    output EN, DIR, SAT, LOAD, LOAD_VAL,
    input  COUNT, TC, WRAP, SAT_HIT
  );

  modport slave (
    input  EN, DIR, SAT, LOAD, LOAD_VAL,
    output COUNT, TC, WRAP, SAT_HIT
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo-(MAX+1) up/down counter with wrap or saturate at the boundaries, clamped load,
// and registered single-cycle WRAP / SAT_HIT pulses. Synchronous active-low reset.
module updown_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 10
) (
  input logic                CLK,
  input logic                RESET,
  updown_mod_counter_if.slave bus
);

  if (MAX < 1 || longint'(MAX) >= (64'sd1 <<< WIDTH)) begin : g_bad_max
    $error("updown_mod_counter: MAX=%0d is outside 1..2**WIDTH-1 for WIDTH=%0d", MAX, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_top, at_bottom;

  assign at_top    = (count_q == MAXV);
  assign at_bottom = (count_q == '0);

  // Priority: load, then step, then hold; pulses clear on anything but a boundary event.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (bus.LOAD) begin
      count_d = (bus.LOAD_VAL > MAXV) ? MAXV : bus.LOAD_VAL;
    end else if (bus.EN) begin
      if (bus.DIR) begin
        if (!at_top) begin
          count_d = count_q + ONE;
        end else if (bus.SAT) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          count_d = count_q - ONE;
        end else if (bus.SAT) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAXV;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.COUNT   = count_q;
  assign bus.WRAP    = wrap_q;
  assign bus.SAT_HIT = sat_q;
  assign bus.TC      = bus.DIR ? at_top : at_bottom;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MAX=10): directed scenarios plus
// a randomized run checked against an arithmetic modulo-(MAX+1) reference model.
module tb_updown_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic CLK;
  logic RESET;
  int   compared;
  int   mismatched;

  // reference model state
  int   m_count;
  bit   m_wrap;
  bit   m_sat;

  updown_mod_counter_if #(.WIDTH(W)) bus ();

  updown_mod_counter #(.WIDTH(W), .MAX(M)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge, updating the model from the inputs presented at that edge.
  task automatic tick();
    int lv;
    lv = int'(bus.LOAD_VAL);
    if (!RESET) begin
      m_count = 0; m_wrap = 0; m_sat = 0;
    end else if (bus.LOAD) begin
      m_count = (lv > M) ? M : lv; m_wrap = 0; m_sat = 0;
    end else if (bus.EN) begin
      if ((bus.DIR && m_count == M) || (!bus.DIR && m_count == 0)) begin
        if (bus.SAT) begin
          m_wrap = 0; m_sat = 1;
        end else begin
          m_count = bus.DIR ? 0 : M; m_wrap = 1; m_sat = 0;
        end
      end else begin
        m_count = bus.DIR ? (m_count + 1) % (M + 1) : (m_count + M) % (M + 1);
        m_wrap = 0; m_sat = 0;
      end
    end else begin
      m_wrap = 0; m_sat = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit en, input bit dir, input bit sat, input bit load, input int lv);
    bus.EN = en; bus.DIR = dir; bus.SAT = sat; bus.LOAD = load; bus.LOAD_VAL = W'(lv);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    drive(1, 1, 0, 1, 5);
    tick();
    tick();
    bus.DIR = 1'b0;
    #1;
    compared += 4;
    if (bus.COUNT !== 4'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", bus.COUNT); end
    if (bus.WRAP !== 1'b0) begin mismatched++; $display("FAIL reset_wrap: got %b want 0", bus.WRAP); end
    if (bus.SAT_HIT !== 1'b0) begin mismatched++; $display("FAIL reset_sat: got %b want 0", bus.SAT_HIT); end
    if (bus.TC !== 1'b1) begin mismatched++; $display("FAIL reset_tc_down: got %b want 1", bus.TC); end
  endtask

  task automatic test_count_up();
    int exp;
    RESET = 1'b1;
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      #1;
      compared++;
      if (bus.TC !== ((i % (M + 1)) == M)) begin
        mismatched++; $display("FAIL up_tc[%0d]: got %b want %b", i, bus.TC, (i % (M + 1)) == M);
      end
      tick();
      exp = (i + 1) % (M + 1);
      compared += 3;
      if (bus.COUNT !== W'(exp)) begin mismatched++; $display("FAIL up_count[%0d]: got %0d want %0d", i, bus.COUNT, exp); end
      if (bus.WRAP !== (exp == 0)) begin mismatched++; $display("FAIL up_wrap[%0d]: got %b want %b", i, bus.WRAP, exp == 0); end
      if (bus.SAT_HIT !== 1'b0) begin mismatched++; $display("FAIL up_sat[%0d]: got %b want 0", i, bus.SAT_HIT); end
    end
  endtask

  task automatic test_wrap_down();
    drive(0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    compared += 2;
    if (bus.COUNT !== 4'd10) begin mismatched++; $display("FAIL down_wrap_count: got %0d want 10", bus.COUNT); end
    if (bus.WRAP !== 1'b1) begin mismatched++; $display("FAIL down_wrap_pulse: got %b want 1", bus.WRAP); end
    tick();
    compared += 2;
    if (bus.COUNT !== 4'd9) begin mismatched++; $display("FAIL down_after_count: got %0d want 9", bus.COUNT); end
    if (bus.WRAP !== 1'b0) begin mismatched++; $display("FAIL down_after_wrap: got %b want 0", bus.WRAP); end
  endtask

  task automatic test_saturate();
    drive(0, 1, 1, 1, 10);
    tick();
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      compared += 3;
      if (bus.COUNT !== 4'd10) begin mismatched++; $display("FAIL sat_count[%0d]: got %0d want 10", i, bus.COUNT); end
      if (bus.SAT_HIT !== 1'b1) begin mismatched++; $display("FAIL sat_hit[%0d]: got %b want 1", i, bus.SAT_HIT); end
      if (bus.WRAP !== 1'b0) begin mismatched++; $display("FAIL sat_wrap[%0d]: got %b want 0", i, bus.WRAP); end
    end
    bus.DIR = 1'b0;
    tick();
    compared += 2;
    if (bus.COUNT !== 4'd9) begin mismatched++; $display("FAIL sat_leave_count: got %0d want 9", bus.COUNT); end
    if (bus.SAT_HIT !== 1'b0) begin mismatched++; $display("FAIL sat_leave_hit: got %b want 0", bus.SAT_HIT); end
    // saturate at the bottom as well
    drive(0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0);
    tick();
    compared += 2;
    if (bus.COUNT !== 4'd0) begin mismatched++; $display("FAIL sat_low_count: got %0d want 0", bus.COUNT); end
    if (bus.SAT_HIT !== 1'b1) begin mismatched++; $display("FAIL sat_low_hit: got %b want 1", bus.SAT_HIT); end
  endtask

  task automatic test_load();
    drive(1, 1, 0, 1, 7);
    tick();
    compared++;
    if (bus.COUNT !== 4'd7) begin mismatched++; $display("FAIL load_7: got %0d want 7", bus.COUNT); end
    bus.LOAD_VAL = 4'd15;
    tick();
    compared++;
    if (bus.COUNT !== 4'd10) begin mismatched++; $display("FAIL load_clamp: got %0d want 10", bus.COUNT); end
    bus.LOAD_VAL = 4'd11;
    tick();
    compared++;
    if (bus.COUNT !== 4'd10) begin mismatched++; $display("FAIL load_clamp11: got %0d want 10", bus.COUNT); end
    RESET = 1'b0;
    bus.LOAD_VAL = 4'd5;
    tick();
    compared++;
    if (bus.COUNT !== 4'd0) begin mismatched++; $display("FAIL load_vs_reset: got %0d want 0", bus.COUNT); end
    RESET = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    drive(0, 1, 0, 1, 10);
    tick();
    drive(1, 1, 0, 0, 0);
    tick();
    compared++;
    if (bus.WRAP !== 1'b1) begin mismatched++; $display("FAIL mid_wrap_set: got %b want 1", bus.WRAP); end
    RESET = 1'b0;
    tick();
    compared += 2;
    if (bus.COUNT !== 4'd0) begin mismatched++; $display("FAIL mid_reset_count: got %0d want 0", bus.COUNT); end
    if (bus.WRAP !== 1'b0) begin mismatched++; $display("FAIL mid_reset_wrap: got %b want 0", bus.WRAP); end
    RESET = 1'b1;
    drive(0, 0, 0, 1, 6);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 0, int'($urandom_range(15)));
      tick();
      compared += 2;
      if (bus.COUNT !== 4'd6) begin mismatched++; $display("FAIL hold_count[%0d]: got %0d want 6", i, bus.COUNT); end
      if ((bus.WRAP | bus.SAT_HIT) !== 1'b0) begin
        mismatched++; $display("FAIL hold_pulse[%0d]: got wrap=%b sat=%b want 0", i, bus.WRAP, bus.SAT_HIT);
      end
    end
    drive(1, 1, 0, 0, 0);
    tick();
    compared++;
    if (bus.COUNT !== 4'd7) begin mismatched++; $display("FAIL resume_count: got %0d want 7", bus.COUNT); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      RESET = ($urandom_range(63) != 0);
      drive(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
            1'($urandom_range(7) == 0), int'($urandom_range(15)));
      tick();
      compared += 6;
      if (bus.COUNT !== W'(m_count)) begin
        mismatched++; errs++;
        if (errs < 20) $display("FAIL rand_count[%0d]: got %0d want %0d", i, bus.COUNT, m_count);
      end
      if (bus.WRAP !== m_wrap) begin
        mismatched++; errs++;
        if (errs < 20) $display("FAIL rand_wrap[%0d]: got %b want %b", i, bus.WRAP, m_wrap);
      end
      if (bus.SAT_HIT !== m_sat) begin
        mismatched++; errs++;
        if (errs < 20) $display("FAIL rand_sat[%0d]: got %b want %b", i, bus.SAT_HIT, m_sat);
      end
      if (bus.TC !== (bus.DIR ? (m_count == M) : (m_count == 0))) begin
        mismatched++; errs++;
        if (errs < 20) $display("FAIL rand_tc[%0d]: got %b want %b", i, bus.TC, bus.DIR ? (m_count == M) : (m_count == 0));
      end
      if (!(bus.COUNT <= 4'd10)) begin
        mismatched++; errs++;
        if (errs < 20) $display("FAIL rand_range[%0d]: got %0d want <= 10", i, bus.COUNT);
      end
      if ((bus.WRAP & bus.SAT_HIT) !== 1'b0) begin
        mismatched++; errs++;
        if (errs < 20) $display("FAIL rand_exclusive[%0d]: got wrap=%b sat=%b want not both", i, bus.WRAP, bus.SAT_HIT);
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    m_count = 0; m_wrap = 0; m_sat = 0;
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_count_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: width of the count register and load value.
REQ-002 Parameter MAX, default 10: terminal value, giving a count range of 0..MAX; legal range 1 <= MAX <= 2**WIDTH-1.
REQ-003 CLK  input  1  clock; all state updates on rising edge only.
REQ-004 RESET  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  count enable; 1 = step by one this cycle.
REQ-006 DIR  input  1  direction; 1 = up, 0 = down.
REQ-007 SAT  input  1  boundary mode; 0 = wrap, 1 = saturate.
REQ-008 LOAD  input  1  synchronous load strobe.
REQ-009 LOAD_VAL  input  WIDTH  value to load.
REQ-010 COUNT  output  WIDTH  registered count value.
REQ-011 TC  output  1  combinational terminal-count flag for the current DIR.
REQ-012 WRAP  output  1  registered single-cycle wrap pulse.
REQ-013 SAT_HIT  output  1  registered single-cycle saturation pulse.

Function
REQ-014 Update priority per rising edge SHALL be RESET, then LOAD, then EN, then hold.
REQ-015 LOAD=1: COUNT <= LOAD_VAL if LOAD_VAL <= MAX, else COUNT <= MAX; EN and DIR ignored; WRAP and SAT_HIT <= 0.
REQ-016 EN=1, DIR=1, COUNT<MAX: COUNT <= COUNT+1.
REQ-017 EN=1, DIR=0, COUNT>0: COUNT <= COUNT-1.
REQ-018 EN=1, DIR=1, COUNT==MAX, SAT=0: COUNT <= 0 and WRAP <= 1 for exactly the next cycle.
REQ-019 EN=1, DIR=0, COUNT==0, SAT=0: COUNT <= MAX and WRAP <= 1 for exactly the next cycle.
REQ-020 EN=1 at a boundary with SAT=1 (up at MAX, or down at 0): COUNT holds, SAT_HIT <= 1 for the next cycle, WRAP <= 0.
REQ-021 EN=0 and LOAD=0: COUNT holds; WRAP and SAT_HIT <= 0.
REQ-022 WRAP and SAT_HIT SHALL never be 1 in the same cycle; each SHALL deassert on the cycle after its event unless the event repeats.
REQ-023 TC = (DIR==1 && COUNT==MAX) || (DIR==0 && COUNT==0), independent of EN and SAT.
REQ-024 DIR, SAT and EN MAY change every cycle; the values sampled at the edge SHALL govern that step, with no pipeline delay.
REQ-025 COUNT SHALL never exceed MAX after any load or step; all arithmetic is in WIDTH bits with no carry out.
REQ-026 An illegal MAX (0, or >= 2**WIDTH) SHALL stop elaboration with an error.

Reset
REQ-027 RESET=0 at a rising edge: COUNT <= 0, WRAP <= 0, SAT_HIT <= 0, overriding LOAD and EN.
REQ-028 Reset asserted mid-count or mid-pulse SHALL take effect at the next edge, leaving no residual pulse; counting resumes on the first edge with RESET=1.
REQ-029 Outputs SHALL be undefined only before the first reset edge; TC follows COUNT combinationally.

Verification (WIDTH=4, MAX=10)
REQ-030 Reset, then EN=1, DIR=1, SAT=0 for 12 edges -> COUNT 1..10, then 0, then 1; WRAP high only in the cycle COUNT=0; TC high while COUNT=10.
REQ-031 From COUNT=0: EN=1, DIR=0, SAT=0 -> COUNT=10 with WRAP=1; next edge -> COUNT=9, WRAP=0.
REQ-032 SAT=1 at COUNT=10, DIR=1, 3 edges -> COUNT stays 10, SAT_HIT=1 each cycle, WRAP=0; then DIR=0 -> COUNT=9, SAT_HIT=0.
REQ-033 LOAD=1, LOAD_VAL=7, EN=1 -> COUNT=7; LOAD_VAL=15 -> COUNT=10; LOAD and RESET both active -> COUNT=0.
REQ-034 RESET=0 during the cycle WRAP=1 -> next edge COUNT=0, WRAP=0; EN=0 with any DIR -> COUNT holds for 5 edges.
REQ-035 Random EN/DIR/SAT/LOAD for 10k cycles against a reference model -> exact match, and COUNT <= 10 always.
